// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction memory:
//   XLEN_DEF       default instruction width
//   HALT_WORD_DEF  encoding that ends execution
//   state_t        fetch-controller states
//   BOOT_IMAGE     built-in program loaded on reset (BOOT_LEN words)
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] HALT_WORD_DEF = 32'hffff_ffff;
    localparam int          BOOT_LEN      = 6;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PROG = 2'd1,
        HALT = 2'd2
    } state_t;

    // Small demo program: addi/add sequence, followed by HALT_WORD in every
    // remaining word of the array.
    localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
        32'h0000_0093,
        32'h0100_0113,
        32'h0640_0193,
        32'h0080_0213,
        32'h0020_82b3,
        32'h0041_8333
    };

endpackage

// File: rtl/imem_boot_rom.sv
// ---------------------------------------------------------------------------
// imem_boot_rom
// Combinational boot-image lookup: word address -> reset value of that word.
// Addresses past the end of the built-in image return HALT_WORD.
// Ports:
//   i_addr  in   ADDR_W  word address
//   o_word  out  XLEN    boot value for that address
// ---------------------------------------------------------------------------
module imem_boot_rom
    import imem_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter int               ADDR_W    = 5,
    parameter logic [XLEN-1:0]  HALT_WORD = XLEN'(HALT_WORD_DEF)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [XLEN-1:0]   o_word
);

    always_comb begin
        o_word = HALT_WORD;
        for (int k = 0; k < BOOT_LEN; k++) begin
            if (32'(i_addr) == 32'(k)) begin
                o_word = XLEN'(BOOT_IMAGE[k]);
            end
        end
    end

endmodule

// File: rtl/instruction_mem.sv
// ---------------------------------------------------------------------------
// instruction_mem
// Re-programmable instruction memory between fetch and decode. Registered
// fetch port (1-cycle latency) with a valid/ready output handshake; a
// program port overwrites words while in program mode. Fetch stops once a
// HALT_WORD has been delivered.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | fetch requests are granted, words delivered over valid/ready
// PROG  | fetch blocked, program-port writes accepted
// HALT  | HALT_WORD delivered; requests ignored until PROG or rst
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   prog_en      in   1       program mode request
//   prog_we      in   1       write strobe (PROG only)
//   prog_addr    in   ADDR_W  write word address
//   prog_data    in   XLEN    write data
//   fetch_req    in   1       fetch request
//   fetch_addr   in   ADDR_W  fetch word address
//   fetch_gnt    out  1       request accepted this cycle (combinational)
//   instr_valid  out  1       instr holds an undelivered word
//   instr_ready  in   1       consumer takes instr this cycle
//   instr        out  XLEN    fetched word
//   halted       out  1       sticky: HALT_WORD delivered
//   fetch_err    out  1       pulse: accepted fetch was out of range
// ---------------------------------------------------------------------------
module instruction_mem
    import imem_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter int               DEPTH     = 32,
    parameter int               ADDR_W    = $clog2(DEPTH),
    parameter logic [XLEN-1:0]  HALT_WORD = XLEN'(HALT_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [XLEN-1:0]   prog_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr,
    output logic              halted,
    output logic              fetch_err
);

    logic [XLEN-1:0] r_mem [DEPTH];
    state_t          r_state;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;
    logic            r_halted;
    logic            r_err;

    logic [XLEN-1:0] w_boot [DEPTH];
    logic            w_fetch_oob;
    logic            w_prog_oob;
    logic            w_deliver;
    logic            w_last;
    logic            w_gnt;
    logic            w_prog_wr;
    logic [XLEN-1:0] w_rd_data;

    // One ROM lookup per word so the whole array reloads on a single edge.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_boot
        imem_boot_rom #(
            .XLEN      (XLEN),
            .ADDR_W    (ADDR_W),
            .HALT_WORD (HALT_WORD)
        ) u_rom (
            .i_addr (ADDR_W'(gi)),
            .o_word (w_boot[gi])
        );
    end

    // Range checks are done at 32 bits so they stay meaningful when DEPTH
    // is not a power of two (address field can exceed the array).
    assign w_fetch_oob = 32'(fetch_addr) >= 32'(DEPTH);
    assign w_prog_oob  = 32'(prog_addr)  >= 32'(DEPTH);

    assign w_deliver = r_valid & instr_ready;

    // Delivering HALT_WORD ends execution on that same edge, so no new
    // fetch may be granted alongside it: the halt word is the last word.
    assign w_last = w_deliver & (r_instr == HALT_WORD);

    assign w_gnt = fetch_req & (r_state == RUN) & ~prog_en
                 & (~r_valid | instr_ready) & ~w_last;

    // prog_en must still be high: a write on the cycle prog_en falls is
    // dropped even though the state is still PROG.
    assign w_prog_wr = (r_state == PROG) & prog_en & prog_we & ~w_prog_oob;

    assign w_rd_data = w_fetch_oob ? HALT_WORD : r_mem[fetch_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_boot[i];
            end
        end else if (w_prog_wr) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_instr  <= HALT_WORD;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                RUN: begin
                    if (prog_en) begin
                        // Held word is discarded when programming starts.
                        r_state  <= PROG;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b0;
                    end else begin
                        if (w_gnt) begin
                            r_instr <= w_rd_data;
                            r_valid <= 1'b1;
                            r_err   <= w_fetch_oob;
                        end else if (w_deliver) begin
                            r_valid <= 1'b0;
                        end
                        if (w_last) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    end
                end
                PROG: begin
                    r_valid  <= 1'b0;
                    r_halted <= 1'b0;
                    if (!prog_en) begin
                        r_state <= RUN;
                    end
                end
                HALT: begin
                    r_valid <= 1'b0;
                    if (prog_en) begin
                        r_state  <= PROG;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_gnt   = w_gnt;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign halted      = r_halted;
    assign fetch_err   = r_err;

endmodule

// File: tb/tb_instruction_mem.sv
module tb_instruction_mem;

    typedef struct {
        logic        pe;
        logic        we;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        req;
        logic [4:0]  fa;
        logic        rdy;
        logic        e_gnt;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        chk_instr;
        logic        e_halted;
        logic        e_err;
    } vec_t;

    logic        clk;
    // main instance, DEPTH=32
    logic        rst, prog_en, prog_we, fetch_req, instr_ready;
    logic [4:0]  prog_addr, fetch_addr;
    logic [31:0] prog_data;
    logic        fetch_gnt, instr_valid, halted, fetch_err;
    logic [31:0] instr;
    // second instance, DEPTH=20 (address field can exceed the array)
    logic        rst2, prog_en2, prog_we2, fetch_req2, instr_ready2;
    logic [4:0]  prog_addr2, fetch_addr2;
    logic [31:0] prog_data2;
    logic        fetch_gnt2, instr_valid2, halted2, fetch_err2;
    logic [31:0] instr2;

    int total = 0;
    int bad   = 0;

    instruction_mem #(.XLEN(32), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .halted(halted), .fetch_err(fetch_err)
    );

    instruction_mem #(.XLEN(32), .DEPTH(20)) dut20 (
        .clk(clk), .rst(rst2), .prog_en(prog_en2), .prog_we(prog_we2),
        .prog_addr(prog_addr2), .prog_data(prog_data2),
        .fetch_req(fetch_req2), .fetch_addr(fetch_addr2), .fetch_gnt(fetch_gnt2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr(instr2),
        .halted(halted2), .fetch_err(fetch_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int pe, input int we, input int pa, input logic [31:0] pd,
                                input int req, input int fa, input int rdy,
                                input int gnt, input int valid, input logic [31:0] ins,
                                input int ci, input int hl, input int er);
        vec_t v;
        v.pe = (pe != 0);   v.we = (we != 0);   v.pa = 5'(pa);   v.pd = pd;
        v.req = (req != 0); v.fa = 5'(fa);      v.rdy = (rdy != 0);
        v.e_gnt = (gnt != 0); v.e_valid = (valid != 0); v.e_instr = ins;
        v.chk_instr = (ci != 0); v.e_halted = (hl != 0); v.e_err = (er != 0);
        return v;
    endfunction

    // Drive at negedge, check the combinational grant before the edge,
    // then the registered outputs just after the edge.
    task automatic run(input int sel, input vec_t v, input string nm);
        @(negedge clk);
        if (sel == 0) begin
            prog_en = v.pe; prog_we = v.we; prog_addr = v.pa; prog_data = v.pd;
            fetch_req = v.req; fetch_addr = v.fa; instr_ready = v.rdy;
        end else begin
            prog_en2 = v.pe; prog_we2 = v.we; prog_addr2 = v.pa; prog_data2 = v.pd;
            fetch_req2 = v.req; fetch_addr2 = v.fa; instr_ready2 = v.rdy;
        end
        #1;
        chk({nm, " gnt"}, 32'(sel == 0 ? fetch_gnt : fetch_gnt2), 32'(v.e_gnt));
        @(posedge clk);
        #1;
        if (sel == 0) begin
            chk({nm, " valid"}, 32'(instr_valid), 32'(v.e_valid));
            if (v.chk_instr) chk({nm, " instr"}, instr, v.e_instr);
            chk({nm, " halted"}, 32'(halted), 32'(v.e_halted));
            chk({nm, " err"}, 32'(fetch_err), 32'(v.e_err));
        end else begin
            chk({nm, " valid"}, 32'(instr_valid2), 32'(v.e_valid));
            if (v.chk_instr) chk({nm, " instr"}, instr2, v.e_instr);
            chk({nm, " halted"}, 32'(halted2), 32'(v.e_halted));
            chk({nm, " err"}, 32'(fetch_err2), 32'(v.e_err));
        end
    endtask

    task automatic reset_chk(input string nm);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " valid"}, 32'(instr_valid), 32'd0);
        chk({nm, " instr"}, instr, 32'hffff_ffff);
        chk({nm, " halted"}, 32'(halted), 32'd0);
        chk({nm, " err"}, 32'(fetch_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [31:0] HW = 32'hffff_ffff;
    vec_t tbl [28];
    vec_t v2  [10];

    initial begin
        rst = 1'b1; prog_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        fetch_req = 0; fetch_addr = 0; instr_ready = 0;
        rst2 = 1'b1; prog_en2 = 0; prog_we2 = 0; prog_addr2 = 0; prog_data2 = 0;
        fetch_req2 = 0; fetch_addr2 = 0; instr_ready2 = 0;

        // boot run, halt, program, backpressure, prog_en rise on held word
        tbl[0]  = mk(0,0,0,0,          1,0,1, 1,1,32'h0000_0093,1,0,0);
        tbl[1]  = mk(0,0,0,0,          1,1,1, 1,1,32'h0100_0113,1,0,0);
        tbl[2]  = mk(0,0,0,0,          1,2,1, 1,1,32'h0640_0193,1,0,0);
        tbl[3]  = mk(0,0,0,0,          1,3,1, 1,1,32'h0080_0213,1,0,0);
        tbl[4]  = mk(0,0,0,0,          1,4,1, 1,1,32'h0020_82b3,1,0,0);
        tbl[5]  = mk(0,0,0,0,          1,5,1, 1,1,32'h0041_8333,1,0,0);
        tbl[6]  = mk(0,0,0,0,          1,6,1, 1,1,HW,1,0,0);
        tbl[7]  = mk(0,0,0,0,          1,7,1, 0,0,HW,1,1,0);
        tbl[8]  = mk(0,0,0,0,          1,0,1, 0,0,HW,1,1,0);
        tbl[9]  = mk(1,1,8,32'h12345678,1,0,1, 0,0,HW,1,0,0);
        tbl[10] = mk(1,1,7,32'h00100093,1,0,1, 0,0,HW,1,0,0);
        tbl[11] = mk(0,1,9,32'h0badf00d,1,7,1, 0,0,HW,1,0,0);
        tbl[12] = mk(0,0,0,0,          1,7,1, 1,1,32'h0010_0093,1,0,0);
        tbl[13] = mk(0,0,0,0,          1,8,1, 1,1,HW,1,0,0);
        tbl[14] = mk(0,0,0,0,          1,9,1, 0,0,HW,1,1,0);
        tbl[15] = mk(1,0,0,0,          0,0,1, 0,0,HW,1,0,0);
        tbl[16] = mk(0,0,0,0,          1,9,1, 0,0,HW,1,0,0);
        tbl[17] = mk(0,0,0,0,          1,2,1, 1,1,32'h0640_0193,1,0,0);
        tbl[18] = mk(0,0,0,0,          1,3,0, 0,1,32'h0640_0193,1,0,0);
        tbl[19] = mk(0,0,0,0,          1,3,0, 0,1,32'h0640_0193,1,0,0);
        tbl[20] = mk(0,0,0,0,          1,3,0, 0,1,32'h0640_0193,1,0,0);
        tbl[21] = mk(0,0,0,0,          1,3,1, 1,1,32'h0080_0213,1,0,0);
        tbl[22] = mk(0,0,0,0,          1,0,1, 1,1,32'h0000_0093,1,0,0);
        tbl[23] = mk(1,0,0,0,          1,1,0, 0,0,32'h0,0,0,0);
        tbl[24] = mk(0,0,0,0,          0,0,1, 0,0,32'h0,0,0,0);
        tbl[25] = mk(0,0,0,0,          1,9,1, 1,1,HW,1,0,0);
        tbl[26] = mk(0,0,0,0,          0,0,0, 0,1,HW,1,0,0);
        tbl[27] = mk(0,0,0,0,          0,0,1, 0,0,HW,1,1,0);

        // DEPTH=20: out-of-range fetch and dropped out-of-range write
        v2[0] = mk(0,0,0,0,           1,25,1, 1,1,HW,1,0,1);
        v2[1] = mk(0,0,0,0,           0,0,1,  0,0,HW,1,1,0);
        v2[2] = mk(1,1,25,32'h12345678,0,0,1,  0,0,HW,1,0,0);
        v2[3] = mk(1,1,25,32'h12345678,0,0,1,  0,0,HW,1,0,0);
        v2[4] = mk(1,1,4,32'h0000abcd, 0,0,1,  0,0,HW,1,0,0);
        v2[5] = mk(0,0,0,0,           0,0,1,  0,0,HW,1,0,0);
        v2[6] = mk(0,0,0,0,           1,5,1,  1,1,32'h0041_8333,1,0,0);
        v2[7] = mk(0,0,0,0,           1,4,1,  1,1,32'h0000_abcd,1,0,0);
        v2[8] = mk(0,0,0,0,           1,19,1, 1,1,HW,1,0,0);
        v2[9] = mk(0,0,0,0,           0,0,1,  0,0,HW,1,1,0);

        @(posedge clk);
        #1;
        chk("reset valid",  32'(instr_valid), 32'd0);
        chk("reset instr",  instr, HW);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset err",    32'(fetch_err), 32'd0);
        chk("reset gnt",    32'(fetch_gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;

        for (int i = 0; i < 28; i++) begin
            run(0, tbl[i], $sformatf("v%0d", i));
        end

        // reset during a held word restores the boot image
        reset_chk("rst1");
        run(0, mk(0,0,0,0, 1,3,0, 1,1,32'h0080_0213,1,0,0), "hold3");
        reset_chk("rst_mid");
        run(0, mk(0,0,0,0, 1,7,1, 1,1,HW,1,0,0), "w7_boot");

        for (int i = 0; i < 10; i++) begin
            run(1, v2[i], $sformatf("d20_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
